// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: redirect/return/jump/branch/sequential
// next-PC selection with stall and a circular return-address stack.
module pc_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int INC       = 4,
    parameter int RESET_VEC = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_target,
    input  logic                         ret,
    input  logic                         j_pc,
    input  logic                         call,
    input  logic [ADDR_W-1:0]            jump_target,
    input  logic                         br_sig,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            br_target,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            pc_plus,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    // ptr_q is the next free slot; the top of stack sits just below it.
    logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
    logic              ras_we;
    logic [PTR_W-1:0]  ras_waddr;
    logic [ADDR_W-1:0] ras_wdata;
    logic [PTR_W-1:0]  top_idx;
    logic [ADDR_W-1:0] ras_top;

    assign pc_plus = pc_q + ADDR_W'(INC);
    assign top_idx = ptr_q - PTR_W'(1);
    assign ras_top = ras_mem_q[top_idx];

    always_comb begin
        pc_d      = pc_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        ras_we    = 1'b0;
        ras_waddr = ptr_q;
        ras_wdata = pc_plus;
        if (redirect) begin
            pc_d = redirect_target;
        end else if (!stall) begin
            if (ret) begin
                if (count_q == '0) begin
                    pc_d  = pc_plus;
                    unf_d = 1'b1;
                    if (j_pc && call) begin
                        ras_we  = 1'b1;
                        ptr_d   = ptr_q + PTR_W'(1);
                        count_d = CNT_W'(1);
                    end
                end else begin
                    pc_d = ras_top;
                    if (j_pc && call) begin
                        // Return-and-call: swap the top entry in place.
                        ras_we    = 1'b1;
                        ras_waddr = top_idx;
                    end else begin
                        ptr_d   = top_idx;
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end else if (j_pc) begin
                pc_d = jump_target;
                if (call) begin
                    ras_we = 1'b1;
                    ptr_d  = ptr_q + PTR_W'(1);
                    if (count_q == FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end else if (br_sig && we) begin
                pc_d = br_target;
            end else begin
                pc_d = pc_plus;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= ADDR_W'(RESET_VEC);
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage is deliberately unreset; only pointer and count matter.
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_mem_q[ras_waddr] <= ras_wdata;
        end
    end

    assign pc            = pc_q;
    assign ras_count     = count_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, reset corner cases, and
// randomized traffic against a queue-based reference model.
module tb_pc_sequencer;
    localparam int AW    = 12;
    localparam int INC   = 4;
    localparam int RV    = 'h10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall, redirect, ret, j_pc, call, br_sig, we;
    logic [AW-1:0] redirect_target, jump_target, br_target;
    logic [AW-1:0] pc, pc_plus;
    logic [2:0]    ras_count;
    logic          ras_overflow, ras_underflow;
    logic [7:0]    pc8, pc_plus8;
    logic [2:0]    ras_count8;
    logic          ovf8, unf8;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_W(AW), .INC(INC), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .ret(ret), .j_pc(j_pc), .call(call),
        .jump_target(jump_target), .br_sig(br_sig), .we(we), .br_target(br_target),
        .pc(pc), .pc_plus(pc_plus), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    // 8-bit copy sees the low byte of every target, so its state is the model mod 256.
    pc_sequencer #(.ADDR_W(8), .INC(INC), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut8 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target[7:0]), .ret(ret), .j_pc(j_pc), .call(call),
        .jump_target(jump_target[7:0]), .br_sig(br_sig), .we(we), .br_target(br_target[7:0]),
        .pc(pc8), .pc_plus(pc_plus8), .ras_count(ras_count8),
        .ras_overflow(ovf8), .ras_underflow(unf8)
    );

    typedef struct {
        logic st, rd; logic [AW-1:0] rt;
        logic rr, jp, cl; logic [AW-1:0] jt;
        logic br, bwe; logic [AW-1:0] bt;
        logic [AW-1:0] epc; int ecnt; logic eovf, eunf;
    } vec_t;
    vec_t tbl[$];

    // Reference model: stack as a queue, newest at the back.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stack[$];
    logic m_ovf, m_unf;

    task automatic m_push(input logic [AW-1:0] a);
        if (m_stack.size() == DEPTH) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
        end
        m_stack.push_back(a);
    endtask

    task automatic model_step();
        logic [AW-1:0] nxt;
        nxt = m_pc + AW'(INC);
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (redirect) m_pc = redirect_target;
        else if (stall) m_pc = m_pc;
        else if (ret) begin
            if (m_stack.size() == 0) begin
                m_unf = 1'b1;
                m_pc = nxt;
            end else begin
                m_pc = m_stack.pop_back();
            end
            if (j_pc && call) m_push(nxt);
        end else if (j_pc) begin
            m_pc = jump_target;
            if (call) m_push(nxt);
        end else if (br_sig && we) m_pc = br_target;
        else m_pc = nxt;
    endtask

    task automatic model_reset();
        m_pc = AW'(RV);
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic row(input logic st, rd, input int rt, input logic rr, jp, cl, input int jt,
                       input logic br, bwe, input int bt, input int epc, ecnt,
                       input logic eovf, eunf);
        vec_t v;
        v.st = st; v.rd = rd; v.rt = AW'(rt); v.rr = rr; v.jp = jp; v.cl = cl;
        v.jt = AW'(jt); v.br = br; v.bwe = bwe; v.bt = AW'(bt);
        v.epc = AW'(epc); v.ecnt = ecnt; v.eovf = eovf; v.eunf = eunf;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic st, rd, input logic [AW-1:0] rt, input logic rr, jp, cl,
                         input logic [AW-1:0] jt, input logic br, bwe, input logic [AW-1:0] bt);
        stall = st; redirect = rd; redirect_target = rt; ret = rr; j_pc = jp; call = cl;
        jump_target = jt; br_sig = br; we = bwe; br_target = bt;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_pc"}, int'(pc), int'(m_pc));
        chk({tag, "_pc_plus"}, int'(pc_plus), int'(AW'(m_pc + AW'(INC))));
        chk({tag, "_cnt"}, int'(ras_count), m_stack.size());
        chk({tag, "_ovf"}, int'(ras_overflow), int'(m_ovf));
        chk({tag, "_unf"}, int'(ras_underflow), int'(m_unf));
        chk({tag, "_pc8"}, int'(pc8), int'(m_pc[7:0]));
        chk({tag, "_pc_plus8"}, int'(pc_plus8), int'(8'(m_pc[7:0] + 8'(INC))));
        chk({tag, "_cnt8"}, int'(ras_count8), m_stack.size());
        chk({tag, "_flags8"}, int'({ovf8, unf8}), int'({m_ovf, m_unf}));
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //    st rd rt     rr jp cl jt     br we bt     epc    cnt ovf unf
        row(0, 0, 0,     0, 0, 0, 0,     0, 0, 0,     'h14,  0, 0, 0);
        row(0, 0, 0,     0, 0, 0, 0,     0, 0, 0,     'h18,  0, 0, 0);
        row(0, 0, 0,     0, 0, 0, 0,     0, 0, 0,     'h1C,  0, 0, 0);
        row(0, 1, 'h20,  0, 0, 0, 0,     0, 0, 0,     'h20,  0, 0, 0);
        row(0, 0, 0,     0, 0, 0, 0,     1, 0, 'h80,  'h24,  0, 0, 0);
        row(0, 1, 'h20,  0, 0, 0, 0,     0, 0, 0,     'h20,  0, 0, 0);
        row(0, 0, 0,     0, 0, 0, 0,     1, 1, 'h80,  'h80,  0, 0, 0);
        row(0, 1, 'h20,  0, 0, 0, 0,     0, 0, 0,     'h20,  0, 0, 0);
        row(1, 0, 0,     0, 0, 0, 0,     1, 1, 'h80,  'h20,  0, 0, 0);
        row(0, 1, 'h40,  0, 0, 0, 0,     0, 0, 0,     'h40,  0, 0, 0);
        row(0, 0, 0,     0, 1, 1, 'h100, 0, 0, 0,     'h100, 1, 0, 0);
        row(0, 0, 0,     0, 1, 1, 'h200, 0, 0, 0,     'h200, 2, 0, 0);
        row(0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     'h104, 1, 0, 0);
        row(0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     'h44,  0, 0, 0);
        row(0, 0, 0,     0, 1, 1, 'h400, 0, 0, 0,     'h400, 1, 0, 0);
        row(0, 0, 0,     0, 1, 1, 'h500, 0, 0, 0,     'h500, 2, 0, 0);
        row(0, 0, 0,     0, 1, 1, 'h600, 0, 0, 0,     'h600, 3, 0, 0);
        row(0, 0, 0,     0, 1, 1, 'h700, 0, 0, 0,     'h700, 4, 0, 0);
        row(0, 0, 0,     0, 1, 1, 'h800, 0, 0, 0,     'h800, 4, 1, 0);
        row(0, 0, 0,     0, 0, 0, 0,     0, 0, 0,     'h804, 4, 0, 0);
        row(1, 1, 'h300, 1, 1, 1, 'h900, 0, 0, 0,     'h300, 4, 0, 0);
        row(0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     'h704, 3, 0, 0);
        row(0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     'h604, 2, 0, 0);
        row(0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     'h504, 1, 0, 0);
        row(0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     'h404, 0, 0, 0);
        row(0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     'h408, 0, 0, 1);
        row(0, 0, 0,     0, 0, 0, 0,     0, 0, 0,     'h40C, 0, 0, 0);
        row(0, 0, 0,     1, 1, 1, 'h900, 0, 0, 0,     'h410, 1, 0, 1);
        row(0, 0, 0,     1, 1, 1, 'h900, 0, 0, 0,     'h410, 1, 0, 0);
        row(0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     'h414, 0, 0, 0);
        row(0, 0, 0,     0, 1, 1, 'hA00, 0, 0, 0,     'hA00, 1, 0, 0);
        row(0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     'h418, 0, 0, 0);
        row(1, 0, 0,     1, 0, 0, 0,     0, 0, 0,     'h418, 0, 0, 0);
        row(0, 1, 'hFFC, 0, 0, 0, 0,     0, 0, 0,     'hFFC, 0, 0, 0);
        row(0, 0, 0,     0, 0, 0, 0,     0, 0, 0,     'h000, 0, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pc", int'(pc), RV);
        chk("rst_pc_plus", int'(pc_plus), RV + INC);
        chk("rst_cnt", int'(ras_count), 0);
        chk("rst_flags", int'({ras_overflow, ras_underflow}), 0);
        chk("rst_pc8", int'(pc8), RV);
        rst_n = 1'b1;
        model_reset();

        // Directed table
        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].rd, tbl[i].rt, tbl[i].rr, tbl[i].jp, tbl[i].cl,
                  tbl[i].jt, tbl[i].br, tbl[i].bwe, tbl[i].bt);
            step();
            chk($sformatf("tbl%0d_pc", i), int'(pc), int'(tbl[i].epc));
            chk($sformatf("tbl%0d_pc_plus", i), int'(pc_plus), int'(AW'(tbl[i].epc + AW'(INC))));
            chk($sformatf("tbl%0d_cnt", i), int'(ras_count), tbl[i].ecnt);
            chk($sformatf("tbl%0d_ovf", i), int'(ras_overflow), int'(tbl[i].eovf));
            chk($sformatf("tbl%0d_unf", i), int'(ras_underflow), int'(tbl[i].eunf));
            chk($sformatf("tbl%0d_pc8", i), int'(pc8), int'(tbl[i].epc[7:0]));
            chk($sformatf("tbl%0d_cnt8", i), int'(ras_count8), tbl[i].ecnt);
        end

        // Async reset in the middle of a call, then held across an active edge
        drive(0, 0, 0, 0, 1, 1, 'h123, 0, 0, 0);
        step();
        chk("pre_rst_cnt", int'(ras_count), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pc", int'(pc), RV);
        chk("async_rst_pc_plus", int'(pc_plus), RV + INC);
        chk("async_rst_cnt", int'(ras_count), 0);
        chk("async_rst_pc8", int'(pc8), RV);
        @(negedge clk);
        chk("held_rst_pc", int'(pc), RV);
        chk("held_rst_cnt", int'(ras_count), 0);
        chk("held_rst_flags", int'({ras_overflow, ras_underflow}), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        model_reset();
        step();
        chk("post_rst_pc", int'(pc), RV + INC);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(7) == 0, $urandom_range(15) == 0, AW'($urandom),
                  $urandom_range(4) == 0, $urandom_range(3) == 0, $urandom_range(1) == 1,
                  AW'($urandom), $urandom_range(1) == 1, $urandom_range(1) == 1, AW'($urandom));
            step();
            chk_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
